alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_addsub.sv | 14 +
 rtl/alu.sv | 52 +++++
 tb/tb_alu.sv | 115 +++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode encoding and barrel-shift helper shared by the ALU files
package alu_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_XOR  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SLT  = 4'd7,
    ALU_SLTU = 4'd8
  } alu_op_e;
  function automatic logic [31:0] barrel(input logic [31:0] a, input logic [4:0] sh, input logic right);
    logic [31:0] s;
    s = a;
    for (int k = 0; k < 5; k++)
      if (sh[k]) s = right ? s >> (1 << k) : s << (1 << k);
    return s;
  endfunction
endpackage

// File: rtl/alu_addsub.sv
// alu_addsub: 32-bit adder, subtracting as a + ~b + 1, with carry and signed overflow
module alu_addsub (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_sub,
  output logic [31:0] o_sum,
  output logic        o_carry,
  output logic        o_overflow
);
  logic [31:0] w_b;
  assign w_b = i_sub ? ~i_b : i_b;
  assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, w_b} + {32'd0, i_sub};
  assign o_overflow = (i_a[31] == w_b[31]) && (o_sum[31] != i_a[31]);
endmodule

// File: rtl/alu.sv
// alu: single-cycle registered ALU with carry/overflow/zero flags
module alu import alu_pkg::*; (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [3:0]  control,
  output logic [31:0] result,
  output logic        carryout,
  output logic        overflow,
  output logic        zero
);
  logic [31:0] w_sum, w_res;
  logic        w_carry, w_ovf, w_arith;
  logic [31:0] r_res;
  logic        r_cy, r_ov, r_zero;
  // slt/sltu reuse the subtractor, so only add selects the non-inverting path
  alu_addsub u_addsub (
    .i_a(operand_a),
    .i_b(operand_b),
    .i_sub(control != ALU_ADD),
    .o_sum(w_sum),
    .o_carry(w_carry),
    .o_overflow(w_ovf)
  );
  assign w_arith = control == ALU_ADD || control == ALU_SUB;
  assign w_res = w_arith               ? w_sum :
                 control == ALU_AND    ? operand_a & operand_b :
                 control == ALU_XOR    ? operand_a ^ operand_b :
                 control == ALU_OR     ? operand_a | operand_b :
                 control == ALU_SLL    ? barrel(operand_a, operand_b[4:0], 1'b0) :
                 control == ALU_SRL    ? barrel(operand_a, operand_b[4:0], 1'b1) :
                 control == ALU_SLT    ? {31'd0, w_sum[31] ^ w_ovf} :
                 control == ALU_SLTU   ? {31'd0, ~w_carry} : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_res  <= '0;
      r_cy   <= 1'b0;
      r_ov   <= 1'b0;
      r_zero <= 1'b1;
    end else begin
      r_res  <= w_res;
      r_cy   <= w_arith & w_carry;
      r_ov   <= w_arith & w_ovf;
      r_zero <= w_res == '0;
    end
  end
  assign result   = r_res;
  assign carryout = r_cy;
  assign overflow = r_ov;
  assign zero     = r_zero;
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed and random checks of alu against an arithmetic reference model
module tb_alu;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] operand_a = '0, operand_b = '0;
  logic [3:0]  control = '0;
  logic [31:0] result;
  logic        carryout, overflow, zero;
  int n_chk = 0, n_fail = 0;
  alu dut (
    .clk(clk), .reset(reset), .operand_a(operand_a), .operand_b(operand_b),
    .control(control), .result(result), .carryout(carryout),
    .overflow(overflow), .zero(zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic c, output logic v);
    longint sa, sb, t;
    logic [32:0] ext;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: begin ext = {1'b0, a} + {1'b0, b}; r = ext[31:0]; c = ext[32];
              t = sa + sb; v = t > 64'sd2147483647 || t < -64'sd2147483648; end
      4'd1: begin r = a - b; c = a >= b;
              t = sa - sb; v = t > 64'sd2147483647 || t < -64'sd2147483648; end
      4'd2: r = a & b;
      4'd3: r = a ^ b;
      4'd4: r = a | b;
      4'd5: r = a << b[4:0];
      4'd6: r = a >> b[4:0];
      4'd7: r = {31'd0, sa < sb};
      4'd8: r = {31'd0, a < b};
      default: ;
    endcase
  endfunction
  task automatic run(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] er;
    logic ec, ev;
    control = op; operand_a = a; operand_b = b;
    @(posedge clk); #1;
    model(op, a, b, er, ec, ev);
    chk({tag, ".result"}, result, er);
    chk({tag, ".carry"}, {31'd0, carryout}, {31'd0, ec});
    chk({tag, ".ovf"}, {31'd0, overflow}, {31'd0, ev});
    chk({tag, ".zero"}, {31'd0, zero}, {31'd0, er == 32'd0});
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, ".result"}, result, 32'd0);
    chk({tag, ".carry"}, {31'd0, carryout}, 32'd0);
    chk({tag, ".ovf"}, {31'd0, overflow}, 32'd0);
    chk({tag, ".zero"}, {31'd0, zero}, 32'd1);
  endtask
  initial begin
    logic [31:0] a, b;
    control = 4'd0; operand_a = 32'd5; operand_b = 32'd7;
    @(posedge clk); #1;
    chk_reset("reset");
    reset = 1'b0;
    run("add_ovf", 4'd0, 32'h7fffffff, 32'h7fffffff);
    chk("add_ovf.lit", result, 32'hfffffffe);
    chk("add_ovf.litv", {31'd0, overflow}, 32'd1);
    run("add_wrap", 4'd0, 32'hffffffff, 32'h00000001);
    chk("add_wrap.litc", {31'd0, carryout}, 32'd1);
    chk("add_wrap.litz", {31'd0, zero}, 32'd1);
    run("sub_neg", 4'd1, 32'd8, 32'd16);
    chk("sub_neg.lit", result, 32'hfffffff8);
    run("sub_pos", 4'd1, 32'd16, 32'd8);
    chk("sub_pos.litc", {31'd0, carryout}, 32'd1);
    run("sub_ovf", 4'd1, 32'h80000000, 32'd1);
    run("sll", 4'd5, 32'hfffffff0, 32'h0000000c);
    chk("sll.lit", result, 32'hffff0000);
    run("srl", 4'd6, 32'h0000ffff, 32'h00000010);
    chk("srl.litz", {31'd0, zero}, 32'd1);
    run("sll0", 4'd5, 32'h12345678, 32'hffffffe0);
    run("srl31", 4'd6, 32'h80000000, 32'h0000001f);
    run("slt", 4'd7, 32'h0000ffff, 32'hffffffff);
    chk("slt.lit", result, 32'd0);
    run("sltu", 4'd8, 32'h0000ffff, 32'hffffffff);
    chk("sltu.lit", result, 32'd1);
    run("sltu_z", 4'd8, 32'hffffffff, 32'h00000010);
    run("slt_neg", 4'd7, 32'h80000000, 32'h7fffffff);
    run("and", 4'd2, 32'hf0f0f0f0, 32'hff00ff00);
    run("xor", 4'd3, 32'hf0f0f0f0, 32'hff00ff00);
    run("or", 4'd4, 32'hf0f0f0f0, 32'h0f0f0f0f);
    run("op9", 4'd9, 32'hffffffff, 32'h00000001);
    run("op15", 4'd15, 32'h7fffffff, 32'h7fffffff);
    reset = 1'b1;
    control = 4'd0; operand_a = 32'd1; operand_b = 32'd1;
    @(posedge clk); #1;
    chk_reset("rst_hold1");
    @(posedge clk); #1;
    chk_reset("rst_hold2");
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_rel.result", result, 32'd2);
    chk("rst_rel.zero", {31'd0, zero}, 32'd0);
    for (int i = 0; i < 400; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) a = {a[31], 31'h7fffffff};
      run("rand", 4'($urandom_range(0, 15)), a, b);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
